// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer that owns HI/LO.
// Each operation is held for a fixed busy window and then committed to
// HI/LO on the last busy edge. stall_req holds HI/LO users in D.
// Optional feature macro: MDU_MADD_EN enables madd (op 101) and msub (op 110).
// Without it those codes are treated as no-ops and no accumulate adder exists.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic        rd_sel,
  input  logic        md_in_d,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req,
  output logic        fsm_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi;
  logic [31:0]      lo;

  logic             op_valid;
  logic             op_div;
  logic             last_cycle;

  // Decode which op codes launch a busy window and which class they belong to.
  always_comb begin
    op_valid = 1'b0;
    op_div   = 1'b0;
    case (op)
      3'b000, 3'b001: op_valid = 1'b1;
      3'b010, 3'b011: begin
        op_valid = 1'b1;
        op_div   = 1'b1;
      end
`ifdef MDU_MADD_EN
      3'b101, 3'b110: op_valid = 1'b1;
`endif
      default: ;
    endcase
  end

  assign last_cycle = (state == S_BUSY) && (cnt == CNT_W'(1));

  // Multiply: only multu (000) is unsigned; mult/madd/msub sign-extend.
  logic        mul_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  assign mul_sgn = (op_q != 3'b000);
  assign mul_a   = {{32{mul_sgn & a_q[31]}}, a_q};
  assign mul_b   = {{32{mul_sgn & b_q[31]}}, b_q};
  assign prod    = mul_a * mul_b;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. The most negative dividend over -1 falls
  // out naturally as 0x80000000 with remainder 0.
  logic        div_sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  assign div_sgn = op_q[0];
  assign a_neg   = div_sgn & a_q[31];
  assign b_neg   = div_sgn & b_q[31];
  assign a_mag   = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag   = b_neg ? (32'd0 - b_q) : b_q;
  assign uq      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign ur      = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quo     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem     = a_neg ? (32'd0 - ur) : ur;

`ifdef MDU_MADD_EN
  // Accumulate against HI/LO as they stand at commit time.
  logic [63:0] acc_add;
  logic [63:0] acc_sub;
  assign acc_add = {hi, lo} + prod;
  assign acc_sub = {hi, lo} - prod;
`endif

  // Sequencer: latch the op on a valid start in IDLE, count the window down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= 3'b000;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && op_valid) begin
            op_q  <= op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            cnt   <= op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state <= S_BUSY;
          end
        end
        default: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_IDLE;
        end
      endcase
    end
  end

  // HI/LO: commit on the last busy edge; mthi/mtlo only when idle and not starting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (last_cycle) begin
      case (op_q)
        3'b000, 3'b001: {hi, lo} <= prod;
        3'b010, 3'b011: begin
          if (b_q != 32'd0) begin
            lo <= quo;
            hi <= rem;
          end
        end
`ifdef MDU_MADD_EN
        3'b101: {hi, lo} <= acc_add;
        3'b110: {hi, lo} <= acc_sub;
`endif
        default: ;
      endcase
    end else if ((state == S_IDLE) && !start && wr_en) begin
      if (wr_sel) lo <= rs_val;
      else        hi <= rs_val;
    end
  end

  assign busy      = (state == S_BUSY);
  assign fsm_state = state;
  assign rd_data   = rd_sel ? lo : hi;
  assign stall_req = md_in_d & (start | busy);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vector table, hand-written multi-cycle sequences
// and randomized operations scored against an arithmetic reference model.
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int MAX_WAIT = 40;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        wr_en;
  logic        wr_sel;
  logic        rd_sel;
  logic        md_in_d;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall_req;
  logic        fsm_state;

  int checks;
  int failures;

  logic [63:0] exp_q[$];

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .wr_en(wr_en), .wr_sel(wr_sel),
    .rd_sel(rd_sel), .md_in_d(md_in_d), .rd_data(rd_data), .busy(busy),
    .stall_req(stall_req), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ph, input logic [31:0] pl,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int cyc);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b;
    v.pre_hi = ph; v.pre_lo = pl; v.exp_hi = eh; v.exp_lo = el; v.exp_cyc = cyc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge only.
  task automatic write_reg(input logic sel, input logic [31:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; rs_val = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic sel, output logic [31:0] v);
    rd_sel = sel;
    #1;
    v = rd_data;
  endtask

  // Counts consecutive busy cycles from the current cycle on, bounded.
  task automatic count_busy(output int nb);
    nb = 0;
    #1;
    while (busy && nb < MAX_WAIT) begin
      nb++;
      @(negedge clk);
      #1;
    end
    if (nb >= MAX_WAIT) check("busy_timeout", 64'(nb), 64'(0));
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    count_busy(nb);
  endtask

  // Reference model: plain arithmetic on the architectural meaning of each op.
  function automatic void ref_exec(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, inout logic [31:0] h,
                                   inout logic [31:0] l, output int cyc);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    cyc = 0;
    case (o)
      3'd0: begin r = ua * ub; {h, l} = r; cyc = MULT_N; end
      3'd1: begin r = sa * sb; {h, l} = r; cyc = MULT_N; end
      3'd2: begin
        cyc = DIV_N;
        if (b != 0) begin l = a / b; h = a % b; end
      end
      3'd3: begin
        cyc = DIV_N;
        if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
`ifdef MDU_MADD_EN
      3'd5: begin r = {h, l} + 64'(sa * sb); {h, l} = r; cyc = MULT_N; end
      3'd6: begin r = {h, l} - 64'(sa * sb); {h, l} = r; cyc = MULT_N; end
`endif
      default: ;
    endcase
  endfunction

  initial begin
    logic [31:0] v, m_hi, m_lo, a, b;
    logic [63:0] exp_v;
    logic [2:0]  o;
    int nb, ecyc, bad;

    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
    wr_en = 1'b0; wr_sel = 1'b0; rd_sel = 1'b0; md_in_d = 1'b1;

    // Reset state
    #2;
    read_reg(1'b0, v); check("reset_hi", 64'(v), 64'(0));
    read_reg(1'b1, v); check("reset_lo", 64'(v), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_state", 64'(fsm_state), 64'(0));
    check("reset_stall", 64'(stall_req), 64'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; md_in_d = 1'b0;

    // Directed vector table
    add_vec("mult",      3'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, MULT_N);
    add_vec("multu",     3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 32'h00000002, 32'hFFFFFFFA, MULT_N);
    add_vec("mult_min",  3'd1, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, MULT_N);
    add_vec("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1, MULT_N);
    add_vec("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N);
    add_vec("div_negd",  3'd3, 32'd7, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFD, DIV_N);
    add_vec("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h1234, 32'h5678, 32'h0, 32'h80000000, DIV_N);
    add_vec("divu",      3'd2, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, DIV_N);
    add_vec("divu_zero", 3'd2, 32'd7, 32'd0, 32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB, DIV_N);
    add_vec("div_zero",  3'd3, 32'hFFFFFFF9, 32'd0, 32'hCCCC, 32'hDDDD, 32'hCCCC, 32'hDDDD, DIV_N);
    add_vec("op_inv7",   3'd7, 32'd5, 32'd6, 32'h11, 32'h22, 32'h11, 32'h22, 0);
`ifdef MDU_MADD_EN
    add_vec("madd",      3'd5, 32'd2, 32'd3, 32'd0, 32'd1, 32'd0, 32'd7, MULT_N);
    add_vec("msub",      3'd6, 32'd4, 32'd4, 32'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF7, MULT_N);
`else
    add_vec("op_inv5",   3'd5, 32'd2, 32'd3, 32'd0, 32'd1, 32'd0, 32'd1, 0);
    add_vec("op_inv6",   3'd6, 32'd4, 32'd4, 32'd0, 32'd7, 32'd0, 32'd7, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      write_reg(1'b0, vecs[i].pre_hi);
      write_reg(1'b1, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
      check({vecs[i].name, "_cyc"}, 64'(nb), 64'(vecs[i].exp_cyc));
      read_reg(1'b0, v); check({vecs[i].name, "_hi"}, 64'(v), 64'(vecs[i].exp_hi));
      read_reg(1'b1, v); check({vecs[i].name, "_lo"}, 64'(v), 64'(vecs[i].exp_lo));
    end

    // mtlo in idle, then stall window and no-bypass read
    write_reg(1'b1, 32'h55);
    read_reg(1'b1, v); check("mtlo_idle", 64'(v), 64'h55);
    md_in_d = 1'b1; start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; rd_sel = 1'b1;
    #1 check("stall_c0", 64'(stall_req), 64'(1));
    @(negedge clk); start = 1'b0;
    bad = 0;
    for (int i = 1; i <= DIV_N; i++) begin
      #1 if (stall_req !== 1'b1) bad++;
      if (i == DIV_N) check("no_bypass", 64'(rd_data), 64'h55);
      @(negedge clk);
    end
    check("stall_window", 64'(bad), 64'(0));
    #1 check("stall_end", 64'(stall_req), 64'(0));
    check("lo_after_stall", 64'(rd_data), 64'd14);
    check("busy_after_stall", 64'(busy), 64'(0));
    md_in_d = 1'b0;

    // mthi and start while busy are both ignored
    write_reg(1'b0, 32'd0);
    @(negedge clk); start = 1'b1; op = 3'd1; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); wr_en = 1'b1; wr_sel = 1'b0; rs_val = 32'h1234;
    @(negedge clk); wr_en = 1'b0; start = 1'b1; op = 3'd2; rs_val = 32'd1; rt_val = 32'd1;
    @(negedge clk); start = 1'b0;
    count_busy(nb);
    check("intf_cyc", 64'(nb + 3), 64'(MULT_N));
    read_reg(1'b0, v); check("intf_hi", 64'(v), 64'hFFFFFFFF);
    read_reg(1'b1, v); check("intf_lo", 64'(v), 64'hFFFFFFFA);

    // wr_en in the start cycle is ignored (divide by zero leaves LO alone)
    write_reg(1'b1, 32'h77);
    @(negedge clk); start = 1'b1; op = 3'd2; rs_val = 32'h99; rt_val = 32'd0;
    wr_en = 1'b1; wr_sel = 1'b1;
    @(negedge clk); start = 1'b0; wr_en = 1'b0;
    count_busy(nb);
    check("wr_start_cyc", 64'(nb), 64'(DIV_N));
    read_reg(1'b1, v); check("wr_start_lo", 64'(v), 64'h77);

    // Back-to-back: a start in cycle N+1 is accepted
    run_op(3'd0, 32'd2, 32'd3, nb);
    start = 1'b1; op = 3'd0; rs_val = 32'd4; rt_val = 32'd5;
    @(negedge clk); start = 1'b0;
    count_busy(nb);
    check("b2b_cyc", 64'(nb), 64'(MULT_N));
    read_reg(1'b1, v); check("b2b_lo", 64'(v), 64'd20);

    // Reset in the middle of a divide
    write_reg(1'b0, 32'h22);
    write_reg(1'b1, 32'h11);
    @(negedge clk); start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    read_reg(1'b0, v); check("rst_mid_hi", 64'(v), 64'(0));
    read_reg(1'b1, v); check("rst_mid_lo", 64'(v), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < DIV_N + 2; i++) begin
      @(negedge clk);
      #1 if (busy !== 1'b0) bad++;
    end
    check("rst_no_busy", 64'(bad), 64'(0));
    read_reg(1'b0, v); check("rst_late_hi", 64'(v), 64'(0));
    read_reg(1'b1, v); check("rst_late_lo", 64'(v), 64'(0));

    // Randomized operations against the reference model
    m_hi = $urandom; m_lo = $urandom;
    write_reg(1'b0, m_hi);
    write_reg(1'b1, m_lo);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom; b = 32'd0; end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
          b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
        end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        m_lo = $urandom;
        write_reg(1'b1, m_lo);
      end
      ref_exec(o, a, b, m_hi, m_lo, ecyc);
      exp_q.push_back({m_hi, m_lo});
      run_op(o, a, b, nb);
      check($sformatf("rnd%0d_op%0d_cyc", i, o), 64'(nb), 64'(ecyc));
      exp_v = exp_q.pop_front();
      read_reg(1'b0, v); check($sformatf("rnd%0d_op%0d_hi", i, o), 64'(v), 64'(exp_v[63:32]));
      read_reg(1'b1, v); check($sformatf("rnd%0d_op%0d_lo", i, o), 64'(v), 64'(exp_v[31:0]));
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer and HI/LO register owner for the pipelined MIPS core. It accepts MD operations from the E stage, latches operands, and holds a busy window of fixed length per operation class. It commits results to HI/LO at the end of that window and raises a stall request so the hazard unit holds any HI/LO-using instruction in D.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  launch MD operation (E stage), one cycle
- op  in  3  000 multu, 001 mult, 010 divu, 011 div, 101 madd, 110 msub; others no-op
- rs_val  in  32  operand A (dividend / multiplicand)
- rt_val  in  32  operand B (divisor / multiplier)
- wr_en  in  1  mthi/mtlo write strobe
- wr_sel  in  1  0 = HI, 1 = LO
- rd_sel  in  1  0 = HI, 1 = LO, selects rd_data
- md_in_d  in  1  decoder flag: instruction in D uses HI/LO or the MDU
- rd_data  out  32  combinational read of selected HI/LO
- busy  out  1  registered, high during the busy window
- stall_req  out  1  md_in_d & (start | busy)

## Operation
- States: IDLE, BUSY. `cnt` counts down the remaining busy cycles.
- IDLE + start + valid op:
  - latch op and operands;
  - load cnt = MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- Invalid op with start: no state change, busy stays low.
- BUSY: decrement cnt each cycle. When cnt == 1, commit the result to HI/LO and return to IDLE.
- mult/multu: {HI,LO} = signed/unsigned 64-bit product.
- madd: {HI,LO} += signed product. msub: {HI,LO} -= signed product. Both use 64-bit wrap-around and the HI/LO values at commit time.
- div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide edge cases:
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
  - Divisor 0: HI and LO unchanged at commit. The busy window still runs its full length.
- wr_en in IDLE with no start: write rs_val to the register chosen by wr_sel at the next edge.
- wr_en while busy, or in the same cycle as start: ignored.
- start while busy: ignored. Latched operands and cnt are unaffected.
- rd_data is always the current HI/LO, with no bypass. Correctness relies on stall_req.

## Timing
- Reset values (async, immediate): HI = 0, LO = 0, busy = 0, cnt = 0, state IDLE, rd_data = 0.
- start sampled high at edge E0:
  - busy is high in cycles 1..N, where N is MULT_CYCLES or DIV_CYCLES;
  - HI/LO update at the edge ending cycle N;
  - new values are readable in cycle N+1, when busy is already low.
- stall_req is combinational and asserts in the start cycle itself, so a following mfhi is held from that cycle on.
- mthi/mtlo: the written value is visible on rd_data one cycle after the wr_en edge.
- Reset mid-operation: the operation is abandoned, no commit, and HI/LO = 0.
- Back-to-back: start accepted in cycle N+1 at the earliest.

## Configuration
- MDU_MADD_EN defined: op codes 101/110 perform madd/msub as above.
- MDU_MADD_EN undefined:
  - 101/110 are invalid ops (no busy, no update);
  - the 64-bit accumulate adder is not synthesized.

## Test plan
- Reset: hold reset_n = 0 mid-DIV, release → HI = LO = 0, busy = 0, no late commit.
- mult, rs = 0xFFFFFFFE, rt = 3:
  - busy high cycles 1..5;
  - cycle 6: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - Same operands as multu → HI = 0x00000002, LO = 0xFFFFFFFA.
- div, rs = -7, rt = 2 → after 10 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu, rt = 0 → HI/LO unchanged, busy still 10 cycles.
- md_in_d = 1 (mflo in D) from the start cycle → stall_req high cycles 0..10, low in cycle 11; rd_data shows the new LO in cycle 11.
- Interference: mthi 0x1234 while busy → ignored; mtlo 0x55 when idle → LO = 0x55 next cycle; start during busy → no effect on the result.
- MDU_MADD_EN defined:
  - sequence: mtlo 1, mthi 0, madd 2×3 → {HI,LO} = 7;
  - msub 4×4 → {HI,LO} = 0xFFFFFFFF_FFFFFFF7.
- MDU_MADD_EN undefined: op 101 → busy never asserts.
